// File: rtl/control_filtro_pa5000_pkg.sv
// Shared codes for the high-pass IIR sequencer: FSM states, mux select codes and the
// per-state output decode used by control_filtro_pa5000.
package control_filtro_pa5000_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P1    = 3'd1,
        P2    = 3'd2,
        P3    = 3'd3,
        P4    = 3'd4,
        P5    = 3'd5,
        SHIFT = 3'd6
    } estado_t;

    // selmuxS: signal operand (dato1)
    localparam logic [2:0] S_FK  = 3'd0;
    localparam logic [2:0] S_FK1 = 3'd1;
    localparam logic [2:0] S_FK2 = 3'd2;
    localparam logic [2:0] S_UK  = 3'd3;
    localparam logic [2:0] S_YK  = 3'd4;

    // selmuxC: coefficient operand (dato2); C_A1/C_A2 already carry the minus sign
    localparam logic [1:0] C_A1 = 2'd0;
    localparam logic [1:0] C_A2 = 2'd1;
    localparam logic [1:0] C_B0 = 2'd2;
    localparam logic [1:0] C_B1 = 2'd3;

    // selmuxZ: addend operand (dato3)
    localparam logic [2:0] Z_ZERO  = 3'd0;
    localparam logic [2:0] Z_ACUM1 = 3'd1;
    localparam logic [2:0] Z_ACUM2 = 3'd2;
    localparam logic [2:0] Z_ACUM3 = 3'd3;
    localparam logic [2:0] Z_UK    = 3'd4;

    // Enable vector, bit i drives en(i+1): yk, fk, fk1, fk2, acum1, acum2, acum3
    localparam logic [6:0] EN_NONE  = 7'b000_0000;
    localparam logic [6:0] EN_YK    = 7'b000_0001;
    localparam logic [6:0] EN_FK    = 7'b000_0010;
    localparam logic [6:0] EN_SHIFT = 7'b000_1100;
    localparam logic [6:0] EN_ACUM1 = 7'b001_0000;
    localparam logic [6:0] EN_ACUM2 = 7'b010_0000;
    localparam logic [6:0] EN_ACUM3 = 7'b100_0000;

    typedef struct packed {
        logic [6:0] en;
        logic [2:0] sel_s;
        logic [1:0] sel_c;
        logic [2:0] sel_z;
        logic       listo;
    } salida_t;

    function automatic salida_t decodifica(input estado_t e);
        salida_t o;
        o = '0;
        case (e)
            P1:      o = '{EN_ACUM1, S_FK1, C_A1, Z_UK,    1'b0};
            P2:      o = '{EN_FK,    S_FK2, C_A2, Z_ACUM1, 1'b0};
            P3:      o = '{EN_ACUM2, S_FK,  C_B0, Z_ZERO,  1'b0};
            P4:      o = '{EN_ACUM3, S_FK1, C_B1, Z_ACUM2, 1'b0};
            P5:      o = '{EN_YK,    S_FK2, C_B0, Z_ACUM3, 1'b0};
            SHIFT:   o = '{EN_SHIFT, S_FK,  C_A1, Z_ZERO,  1'b1};
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/control_filtro_pa5000_contador_ovr.sv
// Saturating overrun counter with sticky flag; clear takes priority over a new overrun.
module contador_ovr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic         flag,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
            cnt  <= '0;
        end else if (clr) begin
            flag <= 1'b0;
            cnt  <= '0;
        end else if (inc) begin
            flag <= 1'b1;
            if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/control_filtro_pa5000.sv
// Moore sequencer driving the 6-step MAC program of the 2nd-order high-pass IIR datapath.
// Optional overrun monitor (clr_ovr, ovr_flag, ovr_cnt) enabled by macro FILTRO_OVR_EN.
module control_filtro_pa5000
    import control_filtro_pa5000_pkg::*;
`ifdef FILTRO_OVR_EN
#(
    parameter int OVR_W = 8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       uk_listo,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       ocupado,
    output logic       listo
`ifdef FILTRO_OVR_EN
    ,
    input  logic             clr_ovr,
    output logic             ovr_flag,
    output logic [OVR_W-1:0] ovr_cnt
`endif
);

    estado_t estado, estado_sig;
    salida_t sal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            estado <= IDLE;
        else
            estado <= estado_sig;
    end

    // NOTE: the default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (uk_listo) estado_sig = P1;
            P1:      estado_sig = P2;
            P2:      estado_sig = P3;
            P3:      estado_sig = P4;
            P4:      estado_sig = P5;
            P5:      estado_sig = SHIFT;
            SHIFT:   estado_sig = uk_listo ? P1 : IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Outputs depend on the state register only, so reset clears them without a clock edge.
    always_comb begin
        sal = decodifica(estado);
    end

    assign en1     = sal.en[0];
    assign en2     = sal.en[1];
    assign en3     = sal.en[2];
    assign en4     = sal.en[3];
    assign en5     = sal.en[4];
    assign en6     = sal.en[5];
    assign en7     = sal.en[6];
    assign selmuxS = sal.sel_s;
    assign selmuxC = sal.sel_c;
    assign selmuxZ = sal.sel_z;
    assign listo   = sal.listo;
    assign ocupado = (estado != IDLE);

`ifdef FILTRO_OVR_EN
    // A sample arriving in SHIFT is accepted back-to-back, so only P1..P5 count as drops.
    logic descarte;
    assign descarte = uk_listo && (estado inside {P1, P2, P3, P4, P5});

    contador_ovr #(.W(OVR_W)) u_contador_ovr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_ovr),
        .inc   (descarte),
        .flag  (ovr_flag),
        .cnt   (ovr_cnt)
    );
`endif

endmodule

// File: tb/tb_control_filtro_pa5000.sv
// Self-checking bench for control_filtro_pa5000 with a behavioural datapath; define FILTRO_OVR_EN
// to also exercise the overrun monitor (built with OVR_W=2).
module tb_control_filtro_pa5000;
    import control_filtro_pa5000_pkg::*;

    localparam int OVR_W = 2;

    logic       clk, reset, uk_listo, clr_ovr;
    logic       en1, en2, en3, en4, en5, en6, en7;
    logic [2:0] selmuxS, selmuxZ;
    logic [1:0] selmuxC;
    logic       ocupado, listo;
    logic             ovr_flag;
    logic [OVR_W-1:0] ovr_cnt;
    logic [6:0] en_vec;

    int tests = 0;
    int fails = 0;

`ifdef FILTRO_OVR_EN
    control_filtro_pa5000 #(.OVR_W(OVR_W)) dut (
        .clk(clk), .reset(reset), .uk_listo(uk_listo),
        .en1(en1), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .en6(en6), .en7(en7),
        .selmuxS(selmuxS), .selmuxC(selmuxC), .selmuxZ(selmuxZ),
        .ocupado(ocupado), .listo(listo),
        .clr_ovr(clr_ovr), .ovr_flag(ovr_flag), .ovr_cnt(ovr_cnt)
    );
`else
    control_filtro_pa5000 dut (
        .clk(clk), .reset(reset), .uk_listo(uk_listo),
        .en1(en1), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .en6(en6), .en7(en7),
        .selmuxS(selmuxS), .selmuxC(selmuxC), .selmuxZ(selmuxZ),
        .ocupado(ocupado), .listo(listo)
    );
    assign ovr_flag = 1'b0;
    assign ovr_cnt  = '0;
`endif

    assign en_vec = {en7, en6, en5, en4, en3, en2, en1};

    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    // ---------------- behavioural model of the program ----------------
    // paso = cycles elapsed since the current sample was accepted (0 = no sample in flight).
    // The program table lists what each of the six cycles must drive.
    localparam logic [6:0] TAB_EN [0:6] = '{
        7'b0000000, 7'b0010000, 7'b0000010, 7'b0100000, 7'b1000000, 7'b0000001, 7'b0001100};
    localparam logic [7:0] TAB_SEL [0:6] = '{
        {3'd0, 2'd0, 3'd0},
        {S_FK1, C_A1, Z_UK},
        {S_FK2, C_A2, Z_ACUM1},
        {S_FK,  C_B0, Z_ZERO},
        {S_FK1, C_B1, Z_ACUM2},
        {S_FK2, C_B0, Z_ACUM3},
        {3'd0, 2'd0, 3'd0}};

    int paso = 0;
    int m_cnt = 0;
    bit m_flag = 1'b0;
    localparam int CNT_MAX = (1 << OVR_W) - 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            paso   <= 0;
            m_cnt  <= 0;
            m_flag <= 1'b0;
        end else begin
            if ((paso == 0 || paso == 6) && uk_listo)
                paso <= 1;
            else if (paso >= 1 && paso <= 5)
                paso <= paso + 1;
            else
                paso <= 0;
            if (clr_ovr) begin
                m_cnt  <= 0;
                m_flag <= 1'b0;
            end else if (uk_listo && paso >= 1 && paso <= 5) begin
                m_flag <= 1'b1;
                m_cnt  <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_en",      32'(en_vec), 32'(TAB_EN[paso]));
            check("cmp_sel",     32'({selmuxS, selmuxC, selmuxZ}), 32'(TAB_SEL[paso]));
            check("cmp_ocupado", 32'(ocupado), 32'(paso != 0));
            check("cmp_listo",   32'(listo), 32'(paso == 6));
`ifdef FILTRO_OVR_EN
            check("cmp_ovr_flag", 32'(ovr_flag), 32'(m_flag));
            check("cmp_ovr_cnt",  32'(ovr_cnt), 32'(m_cnt));
`endif
        end
    end

    // ---------------- behavioural datapath: res = dato1*dato2 + dato3 ----------------
    int coef [0:3] = '{0, 0, 1, -2};
    int u_val = 0;
    int yk, fk, fk1, fk2, acum1, acum2, acum3;
    int d1, d3, res;

    always_comb begin
        d1 = 0;
        d3 = 0;
        case (selmuxS)
            S_FK:    d1 = fk;
            S_FK1:   d1 = fk1;
            S_FK2:   d1 = fk2;
            S_UK:    d1 = u_val;
            S_YK:    d1 = yk;
            default: d1 = 0;
        endcase
        case (selmuxZ)
            Z_ACUM1: d3 = acum1;
            Z_ACUM2: d3 = acum2;
            Z_ACUM3: d3 = acum3;
            Z_UK:    d3 = u_val;
            default: d3 = 0;
        endcase
        res = d1 * coef[selmuxC] + d3;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            yk <= 0; fk <= 0; fk1 <= 0; fk2 <= 0; acum1 <= 0; acum2 <= 0; acum3 <= 0;
        end else begin
            if (en1) yk    <= res;
            if (en2) fk    <= res;
            if (en3) fk1   <= fk;
            if (en4) fk2   <= fk1;
            if (en5) acum1 <= res;
            if (en6) acum2 <= res;
            if (en7) acum3 <= res;
        end
    end

    // ---------------- stimulus ----------------
    // Each call drives inputs for one cycle and returns 1 time unit after the edge that sampled them.
    task automatic cyc(input logic u, input logic c);
        uk_listo = u;
        clr_ovr  = c;
        @(posedge clk);
        #1;
        uk_listo = 1'b0;
        clr_ovr  = 1'b0;
    endtask

    task automatic secuencia_literal(input string tag);
        cyc(1'b1, 1'b0);
        check({tag, "_p1_en"}, 32'(en_vec), 32'(7'b0010000));
        check({tag, "_p1_sel"}, 32'({selmuxS, selmuxC, selmuxZ}), 32'({3'd1, 2'd0, 3'd4}));
        cyc(1'b0, 1'b0);
        check({tag, "_p2_en"}, 32'(en_vec), 32'(7'b0000010));
        cyc(1'b0, 1'b0);
        check({tag, "_p3_en"}, 32'(en_vec), 32'(7'b0100000));
        cyc(1'b0, 1'b0);
        check({tag, "_p4_en"}, 32'(en_vec), 32'(7'b1000000));
        cyc(1'b0, 1'b0);
        check({tag, "_p5_en"}, 32'(en_vec), 32'(7'b0000001));
        check({tag, "_p5_listo"}, 32'(listo), 32'd0);
        cyc(1'b0, 1'b0);
        check({tag, "_shift_en"}, 32'(en_vec), 32'(7'b0001100));
        check({tag, "_shift_listo"}, 32'(listo), 32'd1);
        check({tag, "_shift_ocupado"}, 32'(ocupado), 32'd1);
        cyc(1'b0, 1'b0);
        check({tag, "_idle_ocupado"}, 32'(ocupado), 32'd0);
    endtask

    int listo_t [$];
    int ciclo = 0;
    always @(posedge clk) begin
        ciclo <= ciclo + 1;
        if (listo) listo_t.push_back(ciclo);
    end

    int y_esp [0:3] = '{1, -2, 1, 0};
    int u_seq [0:3] = '{1, 0, 0, 0};

    initial begin
        reset    = 1'b0;
        uk_listo = 1'b0;
        clr_ovr  = 1'b0;
        #2 reset = 1'b1;
        #1;
        // 1. async reset with no clock edge yet
        check("rst_en",      32'(en_vec), 32'd0);
        check("rst_sel",     32'({selmuxS, selmuxC, selmuxZ}), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_listo",   32'(listo), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0);

        // 2. single sample
        secuencia_literal("single");

        // 3. back-to-back: uk_listo during SHIFT
        listo_t.delete();
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        check("b2b_first_listo", 32'(listo), 32'd1);
        cyc(1'b1, 1'b0);
        check("b2b_no_idle_gap", 32'(en_vec), 32'(7'b0010000));
        repeat (5) cyc(1'b0, 1'b0);
        check("b2b_second_listo", 32'(listo), 32'd1);
        cyc(1'b0, 1'b0);
        check("b2b_listo_count", 32'(listo_t.size()), 32'd2);
        if (listo_t.size() == 2)
            check("b2b_listo_spacing", 32'(listo_t[1] - listo_t[0]), 32'd6);

        // 4. drop during P3
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("drop_p4_en", 32'(en_vec), 32'(7'b1000000));
`ifdef FILTRO_OVR_EN
        check("drop_ovr_flag", 32'(ovr_flag), 32'd1);
        check("drop_ovr_cnt",  32'(ovr_cnt), 32'd1);
`endif
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("drop_listo_t6", 32'(listo), 32'd1);
        cyc(1'b0, 1'b0);
        check("drop_back_idle", 32'(ocupado), 32'd0);

        // four more drops saturate the 2-bit counter, then clear beats a simultaneous drop
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
`ifdef FILTRO_OVR_EN
        check("sat_ovr_cnt", 32'(ovr_cnt), 32'd3);
`endif
        cyc(1'b0, 1'b0);
        check("sat_listo", 32'(listo), 32'd1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
`ifdef FILTRO_OVR_EN
        check("clr_prio_cnt",  32'(ovr_cnt), 32'd0);
        check("clr_prio_flag", 32'(ovr_flag), 32'd0);
`endif
        repeat (5) cyc(1'b0, 1'b0);

        // 5. async reset during P4
        listo_t.delete();
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        check("p4_before_reset", 32'(en_vec), 32'(7'b1000000));
        #2 reset = 1'b1;
        #1;
        check("midrst_en",      32'(en_vec), 32'd0);
        check("midrst_ocupado", 32'(ocupado), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) cyc(1'b0, 1'b0);
        check("midrst_no_listo", 32'(listo_t.size()), 32'd0);
        secuencia_literal("after_rst");

        // 6. impulse through the behavioural datapath
        reset = 1'b1;
        #1 reset = 1'b0;
        begin
            int f1, f2, f, y;
            f1 = 0;
            f2 = 0;
            for (int k = 0; k < 4; k++) begin
                u_val = u_seq[k];
                cyc(1'b1, 1'b0);
                repeat (5) cyc(1'b0, 1'b0);
                f = u_seq[k] + coef[C_A1] * f1 + coef[C_A2] * f2;
                y = coef[C_B0] * f + coef[C_B1] * f1 + coef[C_B0] * f2;
                f2 = f1;
                f1 = f;
                check($sformatf("imp_listo_%0d", k), 32'(listo), 32'd1);
                check($sformatf("imp_yk_lit_%0d", k), 32'(yk), 32'(y_esp[k]));
                check($sformatf("imp_yk_eq_%0d", k), 32'(yk), 32'(y));
                cyc(1'b0, 1'b0);
                u_val = 0;
                cyc(1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
